server_dispatcher: RTL and testbench

- Sits directly downstream of the FIFO read port: pops request words from the FIFO and routes each to one of NUM_SERVERS servers over a valid/ready handshake.
- The destination comes from a server-ID field in the word.
- Keeps per-server dispatch counts and a drop count.
- Handles FIFO underflow and stuck servers with a timeout.

---
 rtl/shared_pkg.sv | 21 ++
 rtl/server_dispatcher_sat_counter.sv | 21 ++
 rtl/server_dispatcher.sv | 153 +++++++++++++++
 tb/tb_server_dispatcher.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/shared_pkg.sv
// Shared types for the server dispatcher: word layout and FSM states.
// Imported by the dispatcher and its testbench.
package shared_pkg;

    localparam int FIFO_WIDTH = 16;
    localparam int SRV_ID_W   = 2;
    localparam int PAYLOAD_W  = FIFO_WIDTH - SRV_ID_W;

    typedef enum logic [1:0] {
        IDLE,
        READ,
        CAPTURE,
        SEND
    } state_t;

    typedef struct packed {
        logic [SRV_ID_W-1:0]  id;
        logic [PAYLOAD_W-1:0] payload;
    } word_t;

endpackage

// File: rtl/server_dispatcher_sat_counter.sv
// Saturating up-counter used for dispatch and drop statistics.
// Holds at all-ones instead of wrapping.
module sat_counter #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    // count up on inc, stick at the maximum value
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + WIDTH'(1);
        end
    end

endmodule

// File: rtl/server_dispatcher.sv
// Pops words from a FIFO and hands each to the server named by its ID field.
// Stuck servers are abandoned after a bounded wait and the word is dropped.
module server_dispatcher #(
    parameter int FIFO_WIDTH  = 16,
    parameter int SRV_ID_W    = 2,
    parameter int NUM_SERVERS = 4,
    parameter int TIMEOUT     = 15,
    parameter int CNT_W       = 8
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           empty,
    input  logic [FIFO_WIDTH-1:0]          data_out,
    input  logic                           underflow,
    output logic                           rd_en,
    output logic [NUM_SERVERS-1:0]         srv_valid,
    output logic [FIFO_WIDTH-SRV_ID_W-1:0] srv_data,
    input  logic [NUM_SERVERS-1:0]         srv_ready,
    output logic                           busy,
    output logic                           drop_pulse,
    output logic [NUM_SERVERS*CNT_W-1:0]   disp_cnt,
    output logic [CNT_W-1:0]               drop_cnt
);

    import shared_pkg::*;

    localparam int PW = FIFO_WIDTH - SRV_ID_W;
    localparam int TW = $clog2(TIMEOUT + 1);

    state_t state;
    state_t state_n;

    logic [SRV_ID_W-1:0]    id_q;
    logic [PW-1:0]          pay_q;
    logic                   uf_q;
    logic [TW-1:0]          timer;

    logic                   hs;
    logic                   tmo;
    logic                   rd_en_n;
    logic [NUM_SERVERS-1:0] valid_n;
    logic [PW-1:0]          data_n;

    assign busy = (state != IDLE);

    // handshake only counts on the targeted lane; others are ignored
    assign hs = (state == SEND) && srv_valid[id_q] && srv_ready[id_q];

    // a handshake in the final allowed cycle beats the timeout
    assign tmo = (state == SEND) && !hs
               && (timer == TW'(TIMEOUT - 1));

    // state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    // next-state decode
    always_comb begin
        state_n = state;
        unique case (state)
            IDLE:    if (!empty) state_n = READ;
            READ:    state_n = CAPTURE;
            CAPTURE: state_n = uf_q ? IDLE : SEND;
            SEND:    if (hs || tmo) state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // next values for the registered outputs
    always_comb begin
        rd_en_n = 1'b0;
        valid_n = '0;
        data_n  = srv_data;
        unique case (state)
            IDLE: rd_en_n = !empty;
            CAPTURE: begin
                if (!uf_q) begin
                    valid_n = NUM_SERVERS'(1) << id_q;
                    data_n  = pay_q;
                end
            end
            SEND: begin
                if (!(hs || tmo)) valid_n = srv_valid;
            end
            default: ;
        endcase
    end

    // registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_en      <= 1'b0;
            srv_valid  <= '0;
            srv_data   <= '0;
            drop_pulse <= 1'b0;
        end else begin
            rd_en      <= rd_en_n;
            srv_valid  <= valid_n;
            srv_data   <= data_n;
            drop_pulse <= tmo;
        end
    end

    // sample the FIFO word and underflow flag at the end of READ
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            id_q  <= '0;
            pay_q <= '0;
            uf_q  <= 1'b0;
        end else if (state == READ) begin
            id_q  <= data_out[FIFO_WIDTH-1 -: SRV_ID_W];
            pay_q <= data_out[PW-1:0];
            uf_q  <= underflow;
        end
    end

    // count SEND cycles that ended without a handshake
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            timer <= '0;
        end else if (state == CAPTURE) begin
            timer <= '0;
        end else if ((state == SEND) && !hs && !tmo) begin
            timer <= timer + TW'(1);
        end
    end

    for (genvar i = 0; i < NUM_SERVERS; i++) begin : g_disp
        sat_counter #(
            .WIDTH(CNT_W)
        ) u_disp (
            .clk  (clk),
            .rst  (rst),
            .inc  (hs && (id_q == SRV_ID_W'(i))),
            .count(disp_cnt[i*CNT_W +: CNT_W])
        );
    end

    sat_counter #(
        .WIDTH(CNT_W)
    ) u_drop (
        .clk  (clk),
        .rst  (rst),
        .inc  (tmo),
        .count(drop_cnt)
    );

endmodule

// File: tb/tb_server_dispatcher.sv
// Self-checking bench for server_dispatcher: table vectors, corner
// sequences and randomized words against a transaction-level model.
module tb_server_dispatcher;

    import shared_pkg::*;

    localparam int TMO = 15;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        empty = 1'b1;
    logic [15:0] data_out = '0;
    logic        underflow = 1'b0;
    logic [3:0]  srv_ready = '0;

    logic        rd_en, busy, drop_pulse;
    logic [3:0]  srv_valid;
    logic [13:0] srv_data;
    logic [31:0] disp_cnt;
    logic [7:0]  drop_cnt;

    logic        rd_en_s, busy_s, drop_pulse_s;
    logic [3:0]  srv_valid_s;
    logic [13:0] srv_data_s;
    logic [7:0]  disp_cnt_s;
    logic [1:0]  drop_cnt_s;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    logic [15:0] fifo_q[$];
    bit          pend = 0;

    int disp_m[4];
    int drop_m = 0;

    always #5 clk = ~clk;

    server_dispatcher #(
        .TIMEOUT(TMO),
        .CNT_W  (8)
    ) dut (
        .clk(clk), .rst(rst), .empty(empty),
        .data_out(data_out), .underflow(underflow),
        .rd_en(rd_en), .srv_valid(srv_valid),
        .srv_data(srv_data), .srv_ready(srv_ready),
        .busy(busy), .drop_pulse(drop_pulse),
        .disp_cnt(disp_cnt), .drop_cnt(drop_cnt)
    );

    server_dispatcher #(
        .TIMEOUT(TMO),
        .CNT_W  (2)
    ) dut_sat (
        .clk(clk), .rst(rst), .empty(empty),
        .data_out(data_out), .underflow(underflow),
        .rd_en(rd_en_s), .srv_valid(srv_valid_s),
        .srv_data(srv_data_s), .srv_ready(srv_ready),
        .busy(busy_s), .drop_pulse(drop_pulse_s),
        .disp_cnt(disp_cnt_s), .drop_cnt(drop_cnt_s)
    );

    function automatic void fifo_upd();
        empty    = (fifo_q.size() == 0);
        data_out = empty ? 16'h0 : fifo_q[0];
    endfunction

    // FIFO model: the word read on rd_en leaves the head one cycle later
    always @(negedge clk) begin
        if (pend && fifo_q.size() > 0) begin
            void'(fifo_q.pop_front());
            fifo_upd();
        end
        pend = rd_en;
    end

    function automatic int sat(input int x, input int mx);
        return (x > mx) ? mx : x;
    endfunction

    task automatic chk(input string name,
                       input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h @cyc %0d",
                     name, act, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic chk_counters(input string tag);
        for (int i = 0; i < 4; i++) begin
            chk({tag, "_disp8"}, disp_cnt[i*8 +: 8],
                sat(disp_m[i], 255));
            chk({tag, "_disp2"}, disp_cnt_s[i*2 +: 2],
                sat(disp_m[i], 3));
        end
        chk({tag, "_drop8"}, drop_cnt, sat(drop_m, 255));
        chk({tag, "_drop2"}, drop_cnt_s, sat(drop_m, 3));
    endtask

    task automatic push(input logic [15:0] w);
        fifo_q.push_back(w);
        fifo_upd();
    endtask

    // one word end to end; wt = SEND cycles before the target is ready
    task automatic run_word(input logic [15:0] w16,
                            input int wt,
                            input bit uf,
                            input bit do_push,
                            input logic [3:0] ev,
                            input logic [13:0] ed,
                            input bit edrop,
                            output int t_rd);
        word_t w;
        bit    done;
        w = word_t'(w16);
        t_rd = -1;
        srv_ready = '0;
        if (do_push) push(w16);
        for (int n = 0; n < 10; n++) begin
            tick();
            if (rd_en) begin
                t_rd = cyc;
                break;
            end
        end
        if (t_rd < 0) begin
            chk("rd_en_wait", 1'b0, 1'b1);
            return;
        end
        chk("read_busy", busy, 1'b1);
        chk("read_valid", srv_valid, 4'b0);
        underflow = uf;
        tick();
        underflow = 1'b0;
        chk("rd_en_pulse", rd_en, 1'b0);
        chk("cap_busy", busy, 1'b1);
        chk("cap_valid", srv_valid, 4'b0);
        tick();
        if (uf) begin
            chk("uf_valid", srv_valid, 4'b0);
            chk("uf_busy", busy, 1'b0);
            chk("uf_drop", drop_pulse, 1'b0);
            chk_counters("uf");
            return;
        end
        done = 0;
        for (int k = 0; k < TMO; k++) begin
            chk("send_valid", srv_valid, ev);
            chk("send_data", srv_data, ed);
            chk("send_drop", drop_pulse, 1'b0);
            srv_ready = 4'($urandom) & ~ev;
            if (k == wt) srv_ready = srv_ready | ev;
            tick();
            if (k == wt) begin
                done = 1;
                break;
            end
        end
        srv_ready = '0;
        chk("end_valid", srv_valid, 4'b0);
        chk("end_busy", busy, 1'b0);
        chk("end_drop", drop_pulse, edrop);
        if (done) disp_m[w.id]++;
        else drop_m++;
        chk_counters("end");
        if (!done) begin
            tick();
            chk("drop_one_cycle", drop_pulse, 1'b0);
        end
    endtask

    typedef struct {
        logic [15:0] word;
        int          wt;
        bit          uf;
        logic [3:0]  ev;
        logic [13:0] ed;
        bit          edrop;
    } vec_t;

    vec_t vecs[7];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: no finish, cycle %0d", cyc);
        $fatal(1, "timeout");
    end

    initial begin
        int t1, t2;
        logic [15:0] rw;
        int rwt;
        bit ruf;
        word_t rwd;
        logic [3:0] rev;
        bit rdrop;

        for (int i = 0; i < 4; i++) disp_m[i] = 0;

        vecs[0] = '{16'h8ABC, 0,   0, 4'b0100, 14'h0ABC, 0};
        vecs[1] = '{16'h4001, 5,   0, 4'b0010, 14'h0001, 0};
        vecs[2] = '{16'hC005, 99,  0, 4'b1000, 14'h0005, 1};
        vecs[3] = '{16'h1234, 0,   1, 4'b0000, 14'h0000, 0};
        vecs[4] = '{16'h0003, 14,  0, 4'b0001, 14'h0003, 0};
        vecs[5] = '{16'h7FFF, 15,  0, 4'b0010, 14'h3FFF, 1};
        vecs[6] = '{16'hFFFF, 3,   0, 4'b1000, 14'h3FFF, 0};

        fifo_upd();
        tick();
        tick();
        chk("rst_rd_en", rd_en, 1'b0);
        chk("rst_valid", srv_valid, 4'b0);
        chk("rst_data", srv_data, 14'h0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_drop", drop_pulse, 1'b0);
        chk_counters("rst");
        rst = 1'b0;

        for (int n = 0; n < 3; n++) begin
            tick();
            chk("idle_empty_rd_en", rd_en, 1'b0);
            chk("idle_busy", busy, 1'b0);
        end

        foreach (vecs[i]) begin
            run_word(vecs[i].word, vecs[i].wt, vecs[i].uf, 1,
                     vecs[i].ev, vecs[i].ed, vecs[i].edrop, t1);
        end

        push(16'h8ABC);
        push(16'h4001);
        run_word(16'h8ABC, 0, 0, 0, 4'b0100, 14'h0ABC, 0, t1);
        run_word(16'h4001, 0, 0, 0, 4'b0010, 14'h0001, 0, t2);
        chk("throughput", 32'(t2 - t1), 32'd4);

        for (int i = 0; i < 5; i++) begin
            run_word(16'h0010 + 16'(i), 0, 0, 1, 4'b0001,
                     14'h0010 + 14'(i), 0, t1);
        end
        chk("sat_disp0", disp_cnt_s[1:0], 2'd3);

        push(16'h8123);
        for (int n = 0; n < 10 && !rd_en; n++) tick();
        tick();
        tick();
        chk("pre_rst_valid", srv_valid, 4'b0100);
        #3;
        rst = 1'b1;
        #1;
        for (int i = 0; i < 4; i++) disp_m[i] = 0;
        drop_m = 0;
        chk("async_valid", srv_valid, 4'b0);
        chk("async_busy", busy, 1'b0);
        chk("async_rd_en", rd_en, 1'b0);
        chk_counters("async");
        push(16'h4321);
        for (int n = 0; n < 3; n++) begin
            tick();
            chk("rst_hold_rd_en", rd_en, 1'b0);
        end
        rst = 1'b0;
        run_word(16'h4321, 0, 0, 0, 4'b0010, 14'h0321, 0, t1);

        for (int i = 0; i < 40; i++) begin
            rw    = 16'($urandom);
            rwt   = $urandom_range(0, 20);
            ruf   = ($urandom_range(0, 7) == 0);
            rwd   = word_t'(rw);
            rev   = 4'b0001 << rwd.id;
            rdrop = (rwt >= TMO);
            run_word(rw, rwt, ruf, 1, rev, rwd.payload,
                     rdrop, t1);
        end

        tick();
        chk("final_busy", busy, 1'b0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
